// File: rtl/pixel_frame_capture_if.sv
// Pixel stream in, frame-buffer write port and status out, grouped for pixel_frame_capture.
// master = stream source / status consumer, slave = the capture block.
interface pixel_frame_capture_if #(
   parameter int ADDR_W = 19
);
   logic [7:0]        pixel_i;
   logic              pixel_en_i;
   logic              clear_i;
   logic              wr_en_o;
   logic [ADDR_W-1:0] wr_addr_o;
   logic [7:0]        wr_data_o;
   logic              busy_o;
   logic              frame_done_o;
   logic              frame_valid_o;
   logic              timeout_o;
   logic              overrun_o;
   logic [9:0]        row_o;
   logic [9:0]        col_o;

   modport master (
      output pixel_i, pixel_en_i, clear_i,
      input  wr_en_o, wr_addr_o, wr_data_o, busy_o, frame_done_o,
             frame_valid_o, timeout_o, overrun_o, row_o, col_o
   );

   modport slave (
      input  pixel_i, pixel_en_i, clear_i,
      output wr_en_o, wr_addr_o, wr_data_o, busy_o, frame_done_o,
             frame_valid_o, timeout_o, overrun_o, row_o, col_o
   );
endinterface

// File: rtl/pixel_frame_capture.sv
// Rasterises an 8-bit pixel stream into a linear frame-buffer write port,
// flagging frame completion, stalled streams (timeout) and surplus pixels (overrun).
module pixel_frame_capture #(
   parameter int MAX_ROW = 540,
   parameter int MAX_COL = 540,
   parameter int ADDR_W  = 19,
   parameter int TIMEOUT = 1000000
) (
   input logic                  host_CLK,
   input logic                  rst_n,
   pixel_frame_capture_if.slave bus
);
   localparam int GAP_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE, S_ERR} state_t;

   state_t            r_state, w_next_state;
   logic [9:0]        r_row, r_col;
   logic [ADDR_W-1:0] r_addr, r_wr_addr;
   logic [GAP_W-1:0]  r_gap;
   logic [7:0]        r_wr_data;
   logic              r_wr_en, r_frame_done, r_frame_valid, r_overrun;
   logic              w_accept, w_last, w_timeout;

   assign w_accept  = bus.pixel_en_i && !bus.clear_i &&
                      (r_state == S_IDLE || r_state == S_RECV);
   assign w_last    = (r_row == 10'(MAX_ROW - 1)) && (r_col == 10'(MAX_COL - 1));
   assign w_timeout = (r_state == S_RECV) && !bus.pixel_en_i &&
                      (r_gap == GAP_W'(TIMEOUT - 1));

   // NOTE: rst_n is synchronous, so it is only looked at inside the clocked branch.
   always_ff @(posedge host_CLK) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   // NOTE: the default assignment first keeps this block free of inferred latches.
   always_comb begin
      w_next_state = r_state;
      if (bus.clear_i) begin
         w_next_state = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (bus.pixel_en_i) w_next_state = w_last ? S_DONE : S_RECV;
            S_RECV: begin
               if (bus.pixel_en_i && w_last) w_next_state = S_DONE;
               else if (w_timeout)           w_next_state = S_ERR;
            end
            default: w_next_state = r_state;
         endcase
      end
   end

   // Clear behaves exactly like reset for the datapath; the buffer itself is never touched.
   always_ff @(posedge host_CLK) begin
      if (!rst_n || bus.clear_i) begin
         r_row         <= '0;
         r_col         <= '0;
         r_addr        <= '0;
         r_gap         <= '0;
         r_wr_en       <= 1'b0;
         r_wr_addr     <= '0;
         r_wr_data     <= '0;
         r_frame_done  <= 1'b0;
         r_frame_valid <= 1'b0;
         r_overrun     <= 1'b0;
      end else begin
         r_wr_en       <= w_accept;
         r_frame_done  <= w_accept && w_last;
         r_frame_valid <= (r_state == S_DONE);
         if (w_accept) begin
            r_wr_addr <= r_addr;
            r_wr_data <= bus.pixel_i;
            r_gap     <= '0;
            // Counters hold on the final pixel so DONE reports its position.
            if (!w_last) begin
               r_addr <= r_addr + ADDR_W'(1);
               if (r_col == 10'(MAX_COL - 1)) begin
                  r_col <= '0;
                  r_row <= r_row + 10'd1;
               end else begin
                  r_col <= r_col + 10'd1;
               end
            end
         end else if (r_state == S_RECV) begin
            r_gap <= r_gap + GAP_W'(1);
         end
         if (r_state == S_DONE && bus.pixel_en_i) r_overrun <= 1'b1;
      end
   end

   assign bus.wr_en_o       = r_wr_en;
   assign bus.wr_addr_o     = r_wr_addr;
   assign bus.wr_data_o     = r_wr_data;
   assign bus.busy_o        = (r_state == S_RECV);
   assign bus.frame_done_o  = r_frame_done;
   assign bus.frame_valid_o = r_frame_valid;
   assign bus.timeout_o     = (r_state == S_ERR);
   assign bus.overrun_o     = r_overrun;
   assign bus.row_o         = r_row;
   assign bus.col_o         = r_col;
endmodule

// File: tb/tb_pixel_frame_capture.sv
// Directed bench for pixel_frame_capture with a 4x3 frame and an 8-cycle timeout.
`timescale 1ns/1ps
module tb_pixel_frame_capture;
   localparam int MAX_ROW = 4;
   localparam int MAX_COL = 3;
   localparam int ADDR_W  = 19;
   localparam int TIMEOUT = 8;

   logic host_CLK = 1'b0;
   logic rst_n    = 1'b0;
   int   total    = 0;
   int   bad      = 0;

   pixel_frame_capture_if #(.ADDR_W(ADDR_W)) bus ();

   pixel_frame_capture #(
      .MAX_ROW(MAX_ROW), .MAX_COL(MAX_COL), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .host_CLK(host_CLK),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   always #5 host_CLK = ~host_CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs, then sample the registered result 1 ns after the edge.
   task automatic cyc(input logic en, input logic [7:0] d, input logic clr);
      bus.pixel_en_i = en;
      bus.pixel_i    = d;
      bus.clear_i    = clr;
      @(posedge host_CLK);
      #1;
      bus.pixel_en_i = 1'b0;
      bus.clear_i    = 1'b0;
   endtask

   task automatic check_write(input string tag, input int addr, input logic [7:0] d);
      check({tag, "_wr_en"},   32'(bus.wr_en_o),   32'd1);
      check({tag, "_wr_addr"}, 32'(bus.wr_addr_o), 32'(addr));
      check({tag, "_wr_data"}, 32'(bus.wr_data_o), 32'(d));
   endtask

   initial begin
      bus.pixel_i    = 8'h00;
      bus.pixel_en_i = 1'b0;
      bus.clear_i    = 1'b0;

      // Reset state
      cyc(1'b0, 8'h00, 1'b0);
      cyc(1'b1, 8'hFF, 1'b0);
      check("rst_wr_en",       32'(bus.wr_en_o),       32'd0);
      check("rst_wr_addr",     32'(bus.wr_addr_o),     32'd0);
      check("rst_wr_data",     32'(bus.wr_data_o),     32'd0);
      check("rst_busy",        32'(bus.busy_o),        32'd0);
      check("rst_frame_done",  32'(bus.frame_done_o),  32'd0);
      check("rst_frame_valid", 32'(bus.frame_valid_o), 32'd0);
      check("rst_timeout",     32'(bus.timeout_o),     32'd0);
      check("rst_overrun",     32'(bus.overrun_o),     32'd0);
      check("rst_row",         32'(bus.row_o),         32'd0);
      check("rst_col",         32'(bus.col_o),         32'd0);
      rst_n = 1'b1;
      cyc(1'b0, 8'h00, 1'b0);
      check("idle_wr_en", 32'(bus.wr_en_o), 32'd0);

      // Full frame, back-to-back
      for (int i = 0; i < 12; i++) begin
         cyc(1'b1, 8'(8'h10 + i), 1'b0);
         check_write("full", i, 8'(8'h10 + i));
         check("full_frame_done", 32'(bus.frame_done_o), 32'(i == 11));
         check("full_busy",       32'(bus.busy_o),       32'(i != 11));
         check("full_valid_early", 32'(bus.frame_valid_o), 32'd0);
      end
      cyc(1'b0, 8'h00, 1'b0);
      check("full_post_wr_en",  32'(bus.wr_en_o),       32'd0);
      check("full_post_done",   32'(bus.frame_done_o),  32'd0);
      check("full_frame_valid", 32'(bus.frame_valid_o), 32'd1);
      check("full_row",         32'(bus.row_o),         32'd3);
      check("full_col",         32'(bus.col_o),         32'd2);
      check("full_timeout",     32'(bus.timeout_o),     32'd0);

      // Overrun after a complete frame
      for (int i = 0; i < 2; i++) begin
         cyc(1'b1, 8'hAA, 1'b0);
         check("ovr_wr_en",       32'(bus.wr_en_o),       32'd0);
         check("ovr_frame_valid", 32'(bus.frame_valid_o), 32'd1);
      end
      cyc(1'b0, 8'h00, 1'b0);
      check("ovr_overrun", 32'(bus.overrun_o), 32'd1);
      cyc(1'b0, 8'h00, 1'b1);
      check("ovr_clr_overrun", 32'(bus.overrun_o),     32'd0);
      check("ovr_clr_valid",   32'(bus.frame_valid_o), 32'd0);
      check("ovr_clr_busy",    32'(bus.busy_o),        32'd0);

      // Gapped stream, 5 idle cycles between pixels
      for (int i = 0; i < 12; i++) begin
         cyc(1'b1, 8'(8'h10 + i), 1'b0);
         check_write("gap", i, 8'(8'h10 + i));
         if (i == 2) begin
            check("gap_wrap_row", 32'(bus.row_o), 32'd1);
            check("gap_wrap_col", 32'(bus.col_o), 32'd0);
         end
         for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 8'h00, 1'b0);
            check("gap_idle_wr_en", 32'(bus.wr_en_o),   32'd0);
            check("gap_timeout",    32'(bus.timeout_o), 32'd0);
         end
      end
      check("gap_frame_valid", 32'(bus.frame_valid_o), 32'd1);
      cyc(1'b0, 8'h00, 1'b1);

      // Timeout: 5 pixels then silence
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 8'(8'h20 + i), 1'b0);
         check_write("to", i, 8'(8'h20 + i));
      end
      for (int k = 1; k <= 7; k++) begin
         cyc(1'b0, 8'h00, 1'b0);
         check("to_wait_timeout", 32'(bus.timeout_o), 32'd0);
         check("to_wait_busy",    32'(bus.busy_o),    32'd1);
      end
      cyc(1'b0, 8'h00, 1'b0);
      check("to_timeout", 32'(bus.timeout_o), 32'd1);
      check("to_busy",    32'(bus.busy_o),    32'd0);
      cyc(1'b1, 8'h55, 1'b0);
      check("to_err_wr_en",   32'(bus.wr_en_o),   32'd0);
      check("to_err_timeout", 32'(bus.timeout_o), 32'd1);
      cyc(1'b0, 8'h00, 1'b1);
      check("to_clr_timeout", 32'(bus.timeout_o), 32'd0);
      cyc(1'b1, 8'h66, 1'b0);
      check_write("to_restart", 0, 8'h66);
      cyc(1'b0, 8'h00, 1'b1);

      // Clear colliding with a pixel mid-frame at addr 6
      for (int i = 0; i < 6; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0);
      check_write("coll_pre", 5, 8'h35);
      cyc(1'b1, 8'h77, 1'b1);
      check("coll_wr_en", 32'(bus.wr_en_o), 32'd0);
      check("coll_row",   32'(bus.row_o),   32'd0);
      check("coll_col",   32'(bus.col_o),   32'd0);
      check("coll_busy",  32'(bus.busy_o),  32'd0);
      cyc(1'b1, 8'h88, 1'b0);
      check_write("coll_next", 0, 8'h88);
      check("coll_next_row", 32'(bus.row_o), 32'd0);
      check("coll_next_col", 32'(bus.col_o), 32'd1);
      cyc(1'b0, 8'h00, 1'b1);

      // Reset mid-frame at addr 7
      for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0);
      check_write("rmid_pre", 6, 8'h46);
      rst_n = 1'b0;
      cyc(1'b1, 8'hEE, 1'b0);
      check("rmid_wr_en",   32'(bus.wr_en_o),   32'd0);
      check("rmid_wr_addr", 32'(bus.wr_addr_o), 32'd0);
      check("rmid_wr_data", 32'(bus.wr_data_o), 32'd0);
      check("rmid_busy",    32'(bus.busy_o),    32'd0);
      check("rmid_row",     32'(bus.row_o),     32'd0);
      check("rmid_col",     32'(bus.col_o),     32'd0);
      rst_n = 1'b1;
      cyc(1'b1, 8'h99, 1'b0);
      check_write("rmid_next", 0, 8'h99);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
